// File: rtl/nrzi_frame_tx.sv
// Framed NRZI transmitter: FLAG(RUN+1 ones) + SEP + bit-stuffed payload (MSB first) + GAP.
// A 1 holds the line level and a 0 toggles it, so only FLAG yields a RUN+1 run of held levels.
module nrzi_frame_tx #(
  parameter int W   = 8,
  parameter int RUN = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] tx_data,
  input  logic         tx_valid,
  output logic         tx_ready,
  output logic         x,
  output logic         tx_bit,
  output logic         busy
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FLAG  = 3'd1;
  localparam logic [2:0] S_SEP   = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_STUFF = 3'd4;
  localparam logic [2:0] S_GAP   = 3'd5;

  localparam int CMAX = (W > RUN) ? W : RUN;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int OW   = (RUN > 1) ? $clog2(RUN + 1) : 1;

  logic [2:0]    state_q, state_d;
  logic [W-1:0]  shift_q, shift_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [OW-1:0] ones_q, ones_d;
  logic          x_q, x_d;
  logic          accept;

  always_comb begin
    tx_bit = 1'b0;
    case (state_q)
      S_FLAG:  tx_bit = 1'b1;
      S_DATA:  tx_bit = shift_q[W-1];
      default: tx_bit = 1'b0;
    endcase
  end

  assign tx_ready = (state_q == S_IDLE) || (state_q == S_GAP);
  assign busy     = (state_q != S_IDLE);
  assign accept   = tx_valid && tx_ready;
  assign x        = x_q;

  // cnt_q counts FLAG cycles, then holds the number of payload bits still to send
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    ones_d  = ones_q;
    x_d     = tx_bit ? x_q : ~x_q;
    case (state_q)
      S_IDLE, S_GAP: begin
        if (accept) begin
          state_d = S_FLAG;
          shift_d = tx_data;
          cnt_d   = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FLAG: begin
        if (cnt_q == CW'(RUN)) state_d = S_SEP;
        else                   cnt_d   = cnt_q + CW'(1);
      end
      S_SEP: begin
        state_d = S_DATA;
        cnt_d   = CW'(W);
        ones_d  = '0;
      end
      S_DATA: begin
        shift_d = shift_q << 1;
        cnt_d   = cnt_q - CW'(1);
        ones_d  = tx_bit ? ones_q + OW'(1) : '0;
        // the final payload bit never gets a stuff; GAP already breaks the run
        if (cnt_q == CW'(1))                        state_d = S_GAP;
        else if (tx_bit && ones_q == OW'(RUN - 1))  state_d = S_STUFF;
      end
      S_STUFF: begin
        ones_d  = '0;
        state_d = S_DATA;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      ones_q  <= '0;
      x_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      ones_q  <= ones_d;
      x_q     <= x_d;
    end
  end

endmodule

// File: tb/tb_nrzi_frame_tx.sv
// Self-checking bench: per-cycle expected bit stream built from the framing rules,
// plus a line decoder that finds flags and recovers destuffed payloads from x.
module tb_nrzi_frame_tx;
  localparam int W   = 8;
  localparam int RUN = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [W-1:0] tx_data = '0;
  logic         tx_valid = 1'b0;
  logic         tx_ready, x, tx_bit, busy;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  nrzi_frame_tx #(.W(W), .RUN(RUN)) dut (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .x(x), .tx_bit(tx_bit), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // expected per-cycle stream: bit, ready, tag (2 = last flag bit)
  bit           eb_q[$];
  bit           er_q[$];
  int           et_q[$];
  logic [W-1:0] sent_q[$];
  int           nframes = 0;

  function automatic void put(input bit b, input bit r, input int t);
    eb_q.push_back(b);
    er_q.push_back(r);
    et_q.push_back(t);
  endfunction

  function automatic void push_frame(input logic [W-1:0] w);
    int ones;
    ones = 0;
    for (int i = 0; i <= RUN; i++) put(1'b1, 1'b0, (i == RUN) ? 2 : 1);
    put(1'b0, 1'b0, 0);
    for (int i = W - 1; i >= 0; i--) begin
      put(w[i], 1'b0, 0);
      ones = w[i] ? ones + 1 : 0;
      if (ones == RUN && i > 0) begin
        put(1'b0, 1'b0, 0);
        ones = 0;
      end
    end
    put(1'b0, 1'b1, 0);
    sent_q.push_back(w);
    nframes++;
  endfunction

  logic         x_m, xprev;
  bit           first, a, eb, er, ebusy;
  int           et, prev_tag, run, dphase, nb, dones, zcnt, busy_cnt;
  logic [W-1:0] rw;

  initial begin
    zcnt = 0; busy_cnt = 0; first = 1; run = 0; dphase = 0; prev_tag = 0;
    x_m = 1'b0; xprev = 1'b0; nb = 0; dones = 0; rw = '0;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_x", x, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_rdy", tx_ready, 1'b1);
      check("rst_bit", tx_bit, 1'b0);
      eb_q.delete(); er_q.delete(); et_q.delete(); sent_q.delete();
      x_m = 1'b0; first = 1; run = 0; dphase = 0; prev_tag = 0;
    end else begin
      if (eb_q.size() > 0) begin
        eb = eb_q.pop_front(); er = er_q.pop_front(); et = et_q.pop_front(); ebusy = 1;
      end else begin
        eb = 0; er = 1; et = 0; ebusy = 0;
      end
      check("tx_bit", tx_bit, eb);
      check("busy", busy, ebusy);
      check("tx_ready", tx_ready, er);
      check("x", x, x_m);
      x_m = eb ? x_m : ~x_m;
      if (busy) busy_cnt++;
      // receiver model: a = held level, z on RUN+1 consecutive a
      if (first) first = 0;
      else begin
        a   = (x == xprev);
        run = a ? run + 1 : 0;
        if (run == RUN + 1) begin
          zcnt++;
          check("z_align", prev_tag, 2);
          dphase = 1;
          run = 0;
        end else if (dphase == 1) begin
          dphase = 2; nb = 0; dones = 0; rw = '0;
        end else if (dphase == 2) begin
          if (dones == RUN) dones = 0;
          else begin
            rw = {rw[W-2:0], a};
            nb++;
            dones = a ? dones + 1 : 0;
            if (nb == W) begin
              dphase = 0;
              if (sent_q.size() > 0) check("payload", rw, sent_q.pop_front());
              else check("rx_extra", 1, 0);
            end
          end
        end
      end
      xprev = x;
      prev_tag = et;
    end
  end

  // called at posedge+1; returns at posedge+1 right after the accepting edge
  task automatic send(input logic [W-1:0] w);
    int n;
    tx_data = w;
    tx_valid = 1'b1;
    n = 0;
    while (!tx_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) check("ready_timeout", 0, 1);
    @(posedge clk); #1;
    push_frame(w);
    tx_valid = 1'b0;
    tx_data = W'($urandom);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    repeat (6) begin @(posedge clk); #1; end

    busy_cnt = 0;
    send(8'h00);
    repeat (20) begin @(posedge clk); #1; end
    check("len_00", busy_cnt, 13);

    busy_cnt = 0;
    send(8'hFF);
    repeat (24) begin @(posedge clk); #1; end
    check("len_FF", busy_cnt, 16);

    busy_cnt = 0;
    send(8'hA5);
    send(8'h3C);
    repeat (40) begin @(posedge clk); #1; end
    check("b2b_len", busy_cnt, 28);

    send(8'hFF);
    repeat (7) begin @(posedge clk); #1; end
    #1 rst_n = 1'b0;
    #1;
    check("abort_x", x, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_rdy", tx_ready, 1'b1);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    repeat (8) begin @(posedge clk); #1; end
    busy_cnt = 0;
    send(8'hFF);
    repeat (24) begin @(posedge clk); #1; end
    check("len_post_rst", busy_cnt, 16);

    for (int i = 0; i < 40; i++) begin
      send(W'($urandom));
      if ($urandom_range(0, 2) == 0)
        repeat ($urandom_range(0, 25)) begin @(posedge clk); #1; end
    end
    repeat (40) begin @(posedge clk); #1; end
    check("z_count", zcnt, nframes);
    check("rx_pending", sent_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
